// File: rtl/sram_tile_read_master_pkg.sv
// Shared definitions for the SRAM tile read master.
// Holds the FSM state type, the default geometry of the on-chip SRAM
// (4096 x 32-bit words, runs of 0..4096 words) and a helper that derives
// the byte-enable width from the data width.
package sram_tile_read_master_pkg;

  localparam int DEF_ADDR_W     = 12;  // word address, SRAM depth 4096
  localparam int DEF_DATA_W     = 32;  // SRAM word width
  localparam int DEF_LEN_W      = 13;  // run length 0..4096 words
  localparam int DEF_FIFO_DEPTH = 8;   // return-data FIFO entries

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  // One byte-enable bit per data byte.
  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sram_tile_read_master_if.sv
// Bus bundle of the SRAM tile read master: the Avalon-MM pipelined read
// port towards the SRAM slave and the valid/ready word stream towards the
// operand loaders.
//   master modport : used by the read master (drives requests and stream)
//   slave  modport : used by the SRAM side / stream consumer
interface sram_tile_read_master_if
  import sram_tile_read_master_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  // Avalon-MM read port
  logic [ADDR_W-1:0]           avm_address;
  logic                        avm_chipselect;
  logic                        avm_read;
  logic [be_width(DATA_W)-1:0] avm_byteenable;
  logic                        avm_waitrequest;
  logic                        avm_readdatavalid;
  logic [DATA_W-1:0]           avm_readdata;

  // Output word stream
  logic                        out_valid;
  logic [DATA_W-1:0]           out_data;
  logic                        out_last;
  logic                        out_ready;

  modport master (
    output avm_address, avm_chipselect, avm_read, avm_byteenable,
    input  avm_waitrequest, avm_readdatavalid, avm_readdata,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_read, avm_byteenable,
    output avm_waitrequest, avm_readdatavalid, avm_readdata,
    input  out_valid, out_data, out_last,
    output out_ready
  );

endinterface

// File: rtl/sram_tile_read_master_fifo.sv
// Show-ahead synchronous FIFO for returned read data.
// The head entry is visible on rdata in the same cycle it is written
// behind an empty FIFO's pointer (no extra read latency).
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   push, wdata  : write strobe and data
//   pop          : remove head entry (ignored when empty)
//   rdata        : head entry
//   full, empty  : fill status
//   count        : number of stored entries (0..DEPTH)
// Push and pop together are legal at any fill level, including full.
module sync_fifo_showahead #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count do, so
  // the array maps onto plain RAM/registers without a reset network.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_tile_read_master.sv
// Avalon-MM pipelined read master that streams a contiguous run of words
// from the on-chip SRAM to the systolic-array operand loaders.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   start             : one-cycle command strobe, sampled only in IDLE
//   base_addr         : first word address of the run
//   word_count        : number of words (0 completes without bus reads)
//   busy              : high from start acceptance until done
//   done              : one-cycle completion pulse
//   bus (master)      : Avalon read port and valid/ready output stream
// Reads are issued only while (outstanding + fifo_count) < FIFO_DEPTH, so
// every returning word has a FIFO slot reserved before it is requested.
module sram_tile_read_master
  import sram_tile_read_master_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [LEN_W-1:0]       word_count,
  output logic                   busy,
  output logic                   done,
  sram_tile_read_master_if.master bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  issue_left;
  logic [LEN_W-1:0]  recv_left;
  logic [CNT_W-1:0]  outstanding;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  logic [CNT_W:0]    in_flight;
  logic              rd_req;
  logic              accept;
  logic              push;
  logic              pop;

  // NOTE: every always_comb output gets a default first so no latch can form.
  always_comb begin
    in_flight = {1'b0, outstanding} + {1'b0, fifo_count};
    rd_req    = 1'b0;
    if (state == ISSUE && issue_left != '0 && in_flight < DEPTH_L) rd_req = 1'b1;
  end

  // While stalled, in_flight can only shrink, so rd_req and addr_q hold.
  assign accept = rd_req & ~bus.avm_waitrequest;
  // Returns with nothing outstanding are leftovers from an aborted run.
  assign push   = bus.avm_readdatavalid & (outstanding != '0) & (state != IDLE);
  assign pop    = ~fifo_empty & bus.out_ready;

  assign bus.avm_address    = addr_q;
  assign bus.avm_read       = rd_req;
  assign bus.avm_chipselect = rd_req;
  assign bus.avm_byteenable = '1;
  assign bus.out_valid      = ~fifo_empty;
  assign bus.out_data       = fifo_empty ? '0 : fifo_head;
  assign bus.out_last       = ~fifo_empty & (recv_left == LEN_W'(1));

  sync_fifo_showahead #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (bus.avm_readdata),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      issue_left  <= '0;
      recv_left   <= '0;
      outstanding <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;

      if (accept) begin
        addr_q     <= addr_q + ADDR_W'(1);
        issue_left <= issue_left - LEN_W'(1);
      end

      case ({accept, push})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase

      if (pop) recv_left <= recv_left - LEN_W'(1);

      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (word_count != '0) begin
              addr_q     <= base_addr;
              issue_left <= word_count;
              recv_left  <= word_count;
              state      <= ISSUE;
            end else begin
              state <= DONE;
            end
          end
        end
        ISSUE: begin
          if (accept && issue_left == LEN_W'(1)) state <= DRAIN;
        end
        DRAIN: begin
          // Leave on the cycle the final word is taken downstream.
          if (recv_left == '0 || (recv_left == LEN_W'(1) && pop)) state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The credit rule must keep the return FIFO from ever overflowing.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_sram_tile_read_master.sv
// Directed bench for sram_tile_read_master: SRAM slave model with
// configurable read latency, stream sink, and hand-computed expectations.
module tb_sram_tile_read_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [12:0] word_count = '0;
  logic        busy;
  logic        done;

  sram_tile_read_master_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  sram_tile_read_master dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Word stored at every SRAM address: 0xC<addr>0<addr>.
  function automatic logic [31:0] word_at(input logic [11:0] a);
    return {4'hC, a, 4'h0, a};
  endfunction

  // ---------------- slave / sink drivers ----------------
  int          cyc = 0;
  int          lat = 1;
  logic        rand_wait = 1'b0;
  logic        rand_ready = 1'b0;
  logic        ready_fix = 1'b1;
  logic        inject_rdv = 1'b0;
  logic        wait_q = 1'b0;
  logic        ready_q = 1'b0;
  logic [3:0]        v_pipe = '0;
  logic [3:0][31:0]  d_pipe = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    wait_q  = rand_wait  ? 1'($urandom_range(0, 1)) : 1'b0;
    ready_q = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
  end

  // Fixed-latency read pipeline: a request accepted at an edge returns
  // 'lat' cycles later.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      v_pipe[i] <= v_pipe[i+1];
      d_pipe[i] <= d_pipe[i+1];
    end
    v_pipe[3] <= 1'b0;
    if (bus.avm_read && !bus.avm_waitrequest) begin
      v_pipe[lat-1] <= 1'b1;
      d_pipe[lat-1] <= word_at(bus.avm_address);
    end
  end

  assign bus.avm_waitrequest   = wait_q;
  assign bus.out_ready         = ready_q;
  assign bus.avm_readdatavalid = v_pipe[0] | inject_rdv;
  assign bus.avm_readdata      = inject_rdv ? 32'hDEAD_BEEF : d_pipe[0];

  // ---------------- monitor ----------------
  logic [11:0] acc_q[$];
  int          acc_cyc[$];
  logic [31:0] rx_q[$];
  logic        last_q[$];
  int          n_read_cycles, n_busy, n_done, n_valid;
  int          start_cyc, done_cyc, pop_cyc, first_valid_cyc;
  logic        stall_prev = 1'b0;
  logic [11:0] stall_addr = '0;

  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (start) start_cyc = cyc;
      if (bus.avm_read) n_read_cycles++;
      if (bus.avm_chipselect !== bus.avm_read)
        check("chipselect_eq_read", bus.avm_chipselect, bus.avm_read);
      if (stall_prev) begin
        check("stall_read_held", bus.avm_read, 1'b1);
        check("stall_addr_held", bus.avm_address, stall_addr);
      end
      stall_prev = bus.avm_read && bus.avm_waitrequest;
      stall_addr = bus.avm_address;
      if (bus.avm_read && !bus.avm_waitrequest) begin
        acc_q.push_back(bus.avm_address);
        acc_cyc.push_back(cyc);
      end
      if (bus.out_valid) begin
        n_valid++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (bus.out_valid && bus.out_ready) begin
        rx_q.push_back(bus.out_data);
        last_q.push_back(bus.out_last);
        pop_cyc = cyc;
      end
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_log();
    acc_q.delete(); acc_cyc.delete(); rx_q.delete(); last_q.delete();
    n_read_cycles = 0; n_busy = 0; n_done = 0; n_valid = 0;
    start_cyc = -1; done_cyc = -1; pop_cyc = -1; first_valid_cyc = -1;
  endtask

  task automatic do_start(input logic [11:0] b, input logic [12:0] n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; word_count = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (n_done == 0) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    repeat (3) @(posedge clk);
  endtask

  task automatic check_stream(input string tag, input logic [11:0] b, input int n);
    logic [11:0] a;
    check({tag, "_n_accepts"}, acc_q.size(), n);
    check({tag, "_n_words"}, rx_q.size(), n);
    for (int i = 0; i < n && i < acc_q.size(); i++) begin
      a = b + 12'(i);
      check($sformatf("%s_addr[%0d]", tag, i), acc_q[i], a);
    end
    for (int i = 0; i < n && i < rx_q.size(); i++) begin
      a = b + 12'(i);
      check($sformatf("%s_data[%0d]", tag, i), rx_q[i], word_at(a));
      check($sformatf("%s_last[%0d]", tag, i), last_q[i], (i == n - 1));
    end
    check({tag, "_done_count"}, n_done, 1);
    check({tag, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_log();
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_read", bus.avm_read, 1'b0);
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_last", bus.out_last, 1'b0);
    check("rst_addr", bus.avm_address, 12'h000);
    check("rst_data", bus.out_data, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // T1: base 0x010, 4 words, no stalls, 1-cycle latency.
    clear_log();
    do_start(12'h010, 13'd4);
    wait_done("t1", 100);
    check_stream("t1", 12'h010, 4);
    if (acc_cyc.size() == 4) begin
      check("t1_first_read_cyc", acc_cyc[0] - start_cyc, 1);
      check("t1_back_to_back", acc_cyc[3] - acc_cyc[0], 3);
    end else begin
      check("t1_accept_cycles", acc_cyc.size(), 4);
    end
    if (acc_cyc.size() > 0) check("t1_first_valid_lat", first_valid_cyc - acc_cyc[0], 2);
    check("t1_done_after_pop", (done_cyc - pop_cyc >= 1) && (done_cyc - pop_cyc <= 2), 1'b1);

    // T2: address wrap at the top of the SRAM.
    clear_log();
    do_start(12'hFFE, 13'd4);
    wait_done("t2", 100);
    check_stream("t2", 12'hFFE, 4);

    // T3: zero-length run.
    clear_log();
    do_start(12'h123, 13'd0);
    wait_done("t3", 20);
    check("t3_no_reads", n_read_cycles, 0);
    check("t3_done_lat", done_cyc - start_cyc, 2);
    check("t3_busy_cycles", n_busy, 1);
    check("t3_done_count", n_done, 1);

    // T4: consumer blocked, credit limit of 8 outstanding + buffered.
    clear_log();
    ready_fix = 1'b0;
    @(posedge clk);
    do_start(12'h300, 13'd20);
    repeat (30) @(posedge clk);
    #2;
    check("t4_accepts_blocked", acc_q.size(), 8);
    check("t4_fifo_full_valid", bus.out_valid, 1'b1);
    check("t4_read_throttled", bus.avm_read, 1'b0);
    check("t4_head_data", bus.out_data, word_at(12'h300));
    ready_fix = 1'b1;
    wait_done("t4", 200);
    check_stream("t4", 12'h300, 20);

    // T5: random waitrequest and random out_ready.
    clear_log();
    rand_wait = 1'b1;
    rand_ready = 1'b1;
    @(posedge clk);
    do_start(12'h200, 13'd100);
    wait_done("t5", 3000);
    repeat (5) @(posedge clk);
    rand_wait = 1'b0;
    rand_ready = 1'b0;
    check_stream("t5", 12'h200, 100);
    repeat (3) @(posedge clk);

    // T6: reset mid-ISSUE with two reads outstanding (3-cycle latency).
    clear_log();
    lat = 3;
    do_start(12'h080, 13'd8);
    for (int k = 0; k < 50 && acc_q.size() < 2; k++) @(posedge clk);
    check("t6_two_accepts", acc_q.size(), 2);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("t6_rst_read", bus.avm_read, 1'b0);
    check("t6_rst_cs", bus.avm_chipselect, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_valid", bus.out_valid, 1'b0);
    check("t6_rst_addr", bus.avm_address, 12'h000);
    check("t6_rst_data", bus.out_data, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    inject_rdv = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    inject_rdv = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("t6_no_stale_push", n_valid, 0);
    check("t6_no_done", n_done, 0);
    check("t6_idle_busy", busy, 1'b0);
    check("t6_idle_read", bus.avm_read, 1'b0);

    lat = 1;
    clear_log();
    do_start(12'h040, 13'd3);
    wait_done("t6b", 100);
    check_stream("t6b", 12'h040, 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_tile_read_master.md
Name: sram_tile_read_master

Overview:
Avalon-MM pipelined read master that fetches a contiguous run of 32-bit words from the on-chip dual-port SRAM. It drives one SRAM slave port, either directly or through the interconnect. The words go out on a valid/ready stream that feeds the systolic-array operand loaders. The TPU controller programs a base word address and a length, then pulses start. The block issues reads under credit control so returning data can never overflow its internal FIFO.

Parameters:
ADDR_W, 12, word-address width; matches SRAM depth 4096.
DATA_W, 32, data width.
LEN_W, 13, width of word_count; allows 0..4096 words.
FIFO_DEPTH, 8, return-data FIFO entries; power of two, >=2.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle command strobe; sampled only in IDLE
base_addr  in  ADDR_W  first word address
word_count  in  LEN_W  number of words to read
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse when the last word is accepted downstream
avm_address  out  ADDR_W  read word address
avm_chipselect  out  1  equals avm_read
avm_read  out  1  read request
avm_byteenable  out  DATA_W/8  constant all-ones
avm_waitrequest  in  1  slave stall; holds the request
avm_readdatavalid  in  1  return-data qualifier
avm_readdata  in  DATA_W  returned word
out_valid  out  1  stream data valid
out_data  out  DATA_W  stream word
out_last  out  1  marks the final word of the run
out_ready  in  1  downstream accept

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs go low: busy, done, avm_read, avm_chipselect, out_valid, out_last, avm_address=0, out_data=0. FIFO empty, counters zero.
- State IDLE:
  - start=1 with word_count>0: latch base_addr into addr_q and word_count into issue_left and recv_left. busy=1. Go to ISSUE.
  - start=1 with word_count=0: go to DONE; no bus reads.
- State ISSUE:
  - avm_read asserts when issue_left>0 and (outstanding + fifo_count) < FIFO_DEPTH.
  - While avm_waitrequest=1: avm_address and avm_read are held stable.
  - Request accepted (avm_read & ~avm_waitrequest): addr_q += 1 modulo 2^ADDR_W (4095 wraps to 0); issue_left -= 1; outstanding += 1.
  - When issue_left reaches 0: go to DRAIN.
- Return path (any non-IDLE state):
  - avm_readdatavalid with outstanding>0: push avm_readdata into the FIFO; outstanding -= 1.
  - readdatavalid with outstanding=0 (stale after reset): ignored.
  - The credit rule guarantees the FIFO never overflows. An overflow is an assertion failure.
  - Simultaneous accept and return in one cycle: outstanding is unchanged.
- Stream side:
  - out_valid = FIFO non-empty. out_data = FIFO head; show-ahead, no extra latency.
  - out_last = out_valid & (recv_left==1).
  - Pop on out_valid & out_ready; recv_left -= 1.
  - Simultaneous push and pop are legal at any fill level, including full and empty.
- State DRAIN: wait until recv_left=0, then go to DONE.
- State DONE: done=1 for exactly one cycle, busy=0, go to IDLE. A start that arrives in the DONE cycle is ignored.
- start while busy is ignored; parameters are not re-latched.
- Latency:
  - First avm_read is asserted the cycle after start.
  - With zero waitrequest and 1-cycle readdatavalid latency, the first out_valid comes 2 cycles after the first accept.
  - Sustained throughput is 1 word/cycle when out_ready=1.
- Reset mid-run aborts immediately and produces no done. Bus responses already in flight are discarded by the outstanding=0 rule.

Decomposition:
- Shared package holds:
  - state enum {IDLE, ISSUE, DRAIN, DONE};
  - ADDR_W/DATA_W/LEN_W defaults, matching the SRAM geometry;
  - a function for the byteenable width.
- One sub-module: sync_fifo_showahead. Parameters DATA_W and DEPTH; ports push/pop/full/empty/count; same clk/reset. The top level holds the FSM, address/length counters and the credit counter.

Test Plan:
- base=0x010, count=4, out_ready=1, slave with 1-cycle latency and no waitrequest -> reads at 0x010..0x013 on consecutive cycles; stream data matches preloaded words; out_last on the 4th word; done one cycle after the last pop; busy low afterwards.
- base=0xFFE, count=4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001; 4 words delivered in order.
- count=0 -> no avm_read ever asserted; done pulses 2 cycles after start; busy high for exactly 1 cycle.
- count=20, out_ready held 0 for 30 cycles -> at most 8 reads accepted, FIFO full, no overflow. After out_ready=1, all 20 words arrive in order, out_last on the 20th.
- Random waitrequest (50%) and random out_ready, count=100 -> address stable while stalled; data in order, no loss or duplication; exactly one done.
- reset asserted mid-ISSUE with 2 reads outstanding -> outputs immediately low. Late readdatavalid pulses after release do not push into the FIFO. A new start with count=3 then completes normally.
